// File: rtl/rf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rf_ctrl_pkg
//  Brief    : Shared widths and the writeback holding-slot entry type.
//  Revision : 1.0
// ============================================================================
package rf_ctrl_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 4;
    localparam logic [REG_W-1:0] ZERO_REG = '0;

    // "reg" is a keyword, so the destination index field is named rnum.
    typedef struct packed {
        logic              full;
        logic [REG_W-1:0]  rnum;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_slot.sv
`default_nettype none
// ============================================================================
//  Module   : wb_slot
//  Brief    : One-entry writeback holding buffer; load wins over drain.
//  Revision : 1.0
// ============================================================================
module wb_slot (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load,
    input  logic                          drain,
    input  logic [rf_ctrl_pkg::REG_W-1:0]  load_reg,
    input  logic [rf_ctrl_pkg::DATA_W-1:0] load_data,
    output rf_ctrl_pkg::wb_entry_t        entry
);
    import rf_ctrl_pkg::*;

    wb_entry_t r_entry;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_entry <= '0;
        end else if (load) begin
            r_entry.full <= 1'b1;
            r_entry.rnum <= load_reg;
            r_entry.data <= load_data;
        end else if (drain) begin
            r_entry.full <= 1'b0;
        end
    end

    assign entry = r_entry;

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Brief    : Oldest-first arbiter of two writeback slots onto the register
//             file write port, with pending-write read stall.
//  Revision : 1.0
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_W = rf_ctrl_pkg::DATA_W,
    parameter int REG_W  = rf_ctrl_pkg::REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [REG_W-1:0]  req0_reg,
    input  logic [DATA_W-1:0] req0_data,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [REG_W-1:0]  req1_reg,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [REG_W-1:0]  src_reg1,
    input  logic [REG_W-1:0]  src_reg2,
    output logic              stall,
    output logic [REG_W-1:0]  rf_dst_reg,
    output logic              rf_write_en,
    output logic [DATA_W-1:0] rf_dst_data
);
    import rf_ctrl_pkg::*;

    wb_entry_t         w_slot0;
    wb_entry_t         w_slot1;
    wb_entry_t         w_sel;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_acc0;
    logic              w_acc1;
    logic              w_hit0;
    logic              w_hit1;
    logic              r_rr;
    logic              r_older;
    logic [REG_W-1:0]  r_dst_reg;
    logic              r_write_en;
    logic [DATA_W-1:0] r_dst_data;

    // r_older == 0 means slot 0 holds the older entry.
    always_comb begin
        w_gnt0 = w_slot0.full & (~w_slot1.full | ~r_older);
        w_gnt1 = w_slot1.full & (~w_slot0.full |  r_older);
        w_sel  = w_gnt1 ? w_slot1 : w_slot0;
    end

    assign req0_ready = ~rst & (~w_slot0.full | w_gnt0);
    assign req1_ready = ~rst & (~w_slot1.full | w_gnt1);
    assign w_acc0     = req0_valid & req0_ready;
    assign w_acc1     = req1_valid & req1_ready;

    wb_slot u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .load      (w_acc0),
        .drain     (w_gnt0),
        .load_reg  (req0_reg),
        .load_data (req0_data),
        .entry     (w_slot0)
    );

    wb_slot u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .load      (w_acc1),
        .drain     (w_gnt1),
        .load_reg  (req1_reg),
        .load_data (req1_data),
        .entry     (w_slot1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr    <= 1'b0;
            r_older <= 1'b0;
        end else if (w_acc0 & w_acc1) begin
            r_older <= r_rr;
            r_rr    <= ~r_rr;
        end else if (w_acc0 & w_slot1.full & ~w_gnt1) begin
            r_older <= 1'b1;
        end else if (w_acc1 & w_slot0.full & ~w_gnt0) begin
            r_older <= 1'b0;
        end
    end

    // r0 writes are consumed here so the file's bypass never forwards them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dst_reg  <= '0;
            r_dst_data <= '0;
            r_write_en <= 1'b0;
        end else if (w_gnt0 | w_gnt1) begin
            r_dst_reg  <= w_sel.rnum;
            r_dst_data <= w_sel.data;
            r_write_en <= (w_sel.rnum != ZERO_REG);
        end else begin
            r_write_en <= 1'b0;
        end
    end

    assign rf_dst_reg  = r_dst_reg;
    assign rf_dst_data = r_dst_data;
    assign rf_write_en = r_write_en;

    // The entry already on rf_* is covered by the file bypass, not stalled.
    assign w_hit0 = w_slot0.full & (w_slot0.rnum != ZERO_REG) &
                    ((w_slot0.rnum == src_reg1) | (w_slot0.rnum == src_reg2));
    assign w_hit1 = w_slot1.full & (w_slot1.rnum != ZERO_REG) &
                    ((w_slot1.rnum == src_reg1) | (w_slot1.rnum == src_reg2));
    assign stall  = w_hit0 | w_hit1;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Brief    : Scoreboard bench: accepted writes queued in expected issue order.
//  Revision : 1.0
// ============================================================================
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_reg, req1_reg;
    logic [15:0] req0_data, req1_data;
    logic [3:0]  src_reg1, src_reg2;
    logic        stall;
    logic [3:0]  rf_dst_reg;
    logic        rf_write_en;
    logic [15:0] rf_dst_data;

    regfile_wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_reg    (req0_reg),
        .req0_data   (req0_data),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_reg    (req1_reg),
        .req1_data   (req1_data),
        .src_reg1    (src_reg1),
        .src_reg2    (src_reg2),
        .stall       (stall),
        .rf_dst_reg  (rf_dst_reg),
        .rf_write_en (rf_write_en),
        .rf_dst_data (rf_dst_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  r;
        logic [15:0] d;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         got;
    logic        m_rr;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_wr  = 0;
    logic [15:0] rf_shadow [16];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] r, input logic [15:0] d);
        if (r != 4'd0) exp_q.push_back('{r, d});
    endtask

    // Expected issue order is acceptance order; same-edge ties follow rr.
    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_rr <= 1'b0;
        end else if (req0_valid && req0_ready && req1_valid && req1_ready) begin
            if (m_rr == 1'b0) begin
                push(req0_reg, req0_data);
                push(req1_reg, req1_data);
            end else begin
                push(req1_reg, req1_data);
                push(req0_reg, req0_data);
            end
            m_rr <= ~m_rr;
        end else if (req0_valid && req0_ready) begin
            push(req0_reg, req0_data);
        end else if (req1_valid && req1_ready) begin
            push(req1_reg, req1_data);
        end
    end

    always @(negedge clk) begin
        if (rf_write_en) begin
            n_wr <= n_wr + 1;
            rf_shadow[rf_dst_reg] <= rf_dst_data;
            if (exp_q.size() == 0) begin
                chk("spurious_write", 32'd1, 32'd0);
            end else begin
                got = exp_q.pop_front();
                chk("sb_reg", {28'd0, rf_dst_reg}, {28'd0, got.r});
                chk("sb_data", {16'd0, rf_dst_data}, {16'd0, got.d});
            end
        end
    end

    task automatic stream(input int port);
        logic acc;
        for (int i = 0; i < 8; i++) begin
            if (port == 0) begin
                req0_reg = 4'(i % 7 + 1); req0_data = 16'h0A00 + 16'(i); req0_valid = 1'b1;
            end else begin
                req1_reg = 4'(i % 7 + 8); req1_data = 16'h0B00 + 16'(i); req1_valid = 1'b1;
            end
            for (int t = 0; t < 40; t++) begin
                acc = (port == 0) ? req0_ready : req1_ready;
                @(negedge clk);
                if (acc) break;
                if (t == 39) chk("stream_timeout", 32'd0, 32'd1);
            end
        end
        if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int wr_base;
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_reg = '0; req1_reg = '0; req0_data = '0; req1_data = '0;
        src_reg1 = '0; src_reg2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_we",     {31'd0, rf_write_en}, 32'd0);
        chk("rst_reg",    {28'd0, rf_dst_reg},  32'd0);
        chk("rst_data",   {16'd0, rf_dst_data}, 32'd0);
        chk("rst_stall",  {31'd0, stall},       32'd0);
        chk("rst_ready0", {31'd0, req0_ready},  32'd0);
        chk("rst_ready1", {31'd0, req1_ready},  32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single uncontended request
        src_reg1 = 4'd3;
        req0_valid = 1'b1; req0_reg = 4'd3; req0_data = 16'h1234;
        @(negedge clk);
        req0_valid = 1'b0;
        chk("single_stall_held", {31'd0, stall},       32'd1);
        chk("single_we_early",   {31'd0, rf_write_en}, 32'd0);
        @(negedge clk);
        chk("single_we",    {31'd0, rf_write_en}, 32'd1);
        chk("single_reg",   {28'd0, rf_dst_reg},  32'd3);
        chk("single_data",  {16'd0, rf_dst_data}, 32'h1234);
        chk("single_stall_drained", {31'd0, stall}, 32'd0);
        @(negedge clk);
        chk("single_we_off", {31'd0, rf_write_en}, 32'd0);

        // Simultaneous accept, rr = 0 then rr = 1
        req0_valid = 1'b1; req0_reg = 4'd5; req0_data = 16'hAAAA;
        req1_valid = 1'b1; req1_reg = 4'd6; req1_data = 16'h5555;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("sim_first_reg",  {28'd0, rf_dst_reg}, 32'd5);
        @(negedge clk);
        chk("sim_second_reg", {28'd0, rf_dst_reg}, 32'd6);
        req0_valid = 1'b1; req0_reg = 4'd8; req0_data = 16'h0808;
        req1_valid = 1'b1; req1_reg = 4'd9; req1_data = 16'h0909;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("rr_first_reg",  {28'd0, rf_dst_reg}, 32'd9);
        @(negedge clk);
        chk("rr_second_reg", {28'd0, rf_dst_reg}, 32'd8);
        @(negedge clk);

        // Same-register ordering
        req1_valid = 1'b1; req1_reg = 4'd7; req1_data = 16'h0001;
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_reg = 4'd7; req0_data = 16'h0002;
        @(negedge clk);
        req0_valid = 1'b0;
        chk("order_first",  {16'd0, rf_dst_data}, 32'h0001);
        @(negedge clk);
        chk("order_second", {16'd0, rf_dst_data}, 32'h0002);
        @(negedge clk);
        chk("order_final_r7", {16'd0, rf_shadow[7]}, 32'h0002);

        // Register 0
        src_reg1 = 4'd0;
        req0_valid = 1'b1; req0_reg = 4'd0; req0_data = 16'hFFFF;
        @(negedge clk);
        req0_valid = 1'b0;
        chk("r0_stall", {31'd0, stall}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            chk("r0_we", {31'd0, rf_write_en}, 32'd0);
            @(negedge clk);
        end
        chk("r0_consumed_ready", {31'd0, req0_ready}, 32'd1);

        // Both requesters streaming
        wr_base = n_wr;
        fork
            stream(0);
            stream(1);
        join
        repeat (6) @(negedge clk);
        chk("stream_writes", n_wr - wr_base, 32'd16);
        chk("stream_queue_empty", exp_q.size(), 32'd0);

        // Reset with both slots full
        src_reg1 = 4'd11;
        req0_valid = 1'b1; req0_reg = 4'd11; req0_data = 16'hC0DE;
        req1_valid = 1'b1; req1_reg = 4'd12; req1_data = 16'hBEEF;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("pre_rst_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_we",     {31'd0, rf_write_en}, 32'd0);
        chk("mid_rst_reg",    {28'd0, rf_dst_reg},  32'd0);
        chk("mid_rst_data",   {16'd0, rf_dst_data}, 32'd0);
        chk("mid_rst_stall",  {31'd0, stall},       32'd0);
        chk("mid_rst_ready0", {31'd0, req0_ready},  32'd0);
        rst = 1'b0;
        wr_base = n_wr;
        repeat (4) @(negedge clk);
        chk("post_rst_no_write", n_wr - wr_base, 32'd0);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
